edge_grad_3x3: RTL and testbench

Parametrised 3x3 gradient edge detector: takes three vertically aligned pixel rows from the line buffer, forms a sliding 3x3 window per channel, and computes |Gx|+|Gy| with a runtime-selectable Prewitt or Sobel kernel. Output magnitude saturates to the pixel range. A column counter blanks the window-fill border, and a valid pipeline marks each result. It sits between the line buffer and the display/frame-write path, replacing the fixed 24-bit Prewitt-only stage.

---
 rtl/edge_pkg.sv | 29 ++
 rtl/edge_grad_ch.sv | 122 ++++++++++++
 rtl/edge_grad_3x3.sv | 90 +++++++++
 tb/tb_edge_grad_3x3.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// +------------------------------------------------------------------------+
// | edge_pkg                                                               |
// | Shared constants, kernel select encoding and width helpers for the     |
// | 3x3 gradient edge detector.                                            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package edge_pkg;

    typedef enum logic {
        KERNEL_PREWITT = 1'b0,
        KERNEL_SOBEL   = 1'b1
    } kernel_e;

    localparam int EDGE_LAT = 4;

    // Signed gradient / unsigned magnitude width for a DW-bit pixel
    function automatic int grad_w(input int dw);
        return dw + 4;
    endfunction

    function automatic int col_w(input int pic_width);
        return (pic_width > 1) ? $clog2(pic_width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_grad_ch.sv
// +------------------------------------------------------------------------+
// | edge_grad_ch                                                           |
// | One channel: 3x3 window, Gx/Gy, |Gx|+|Gy|, saturation and optional     |
// | binarisation (EDGE_THRESH_EN).                                         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module edge_grad_ch
    import edge_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_shift,
    input  logic          i_sobel,
    input  logic          i_load,
    input  logic          i_border,
    input  logic [DW-1:0] i_thr,
    input  logic [DW-1:0] i_top,
    input  logic [DW-1:0] i_mid,
    input  logic [DW-1:0] i_bot,
    output logic [DW-1:0] o_dout
);

    localparam int GW = grad_w(DW);
    localparam logic [DW-1:0] c_pix_max = {DW{1'b1}};

    // Column index 0 = left (oldest), 2 = right (newest)
    logic [DW-1:0]        r_top [3];
    logic [DW-1:0]        r_mid [3];
    logic [DW-1:0]        r_bot [3];
    logic signed [GW-1:0] r_gx;
    logic signed [GW-1:0] r_gy;
    logic [GW-1:0]        r_mag;
    logic [DW-1:0]        r_dout;

    logic [GW-1:0] w_gx_pos;
    logic [GW-1:0] w_gx_neg;
    logic [GW-1:0] w_gy_pos;
    logic [GW-1:0] w_gy_neg;
    logic [GW-1:0] w_abs_gx;
    logic [GW-1:0] w_abs_gy;
    logic [DW-1:0] w_sat;
    logic [DW-1:0] w_res;

    function automatic logic [GW-1:0] tap3(
        input logic [DW-1:0] a,
        input logic [DW-1:0] m,
        input logic [DW-1:0] b,
        input logic          sobel
    );
        logic [GW-1:0] w_m;
        w_m = sobel ? (GW'(m) << 1) : GW'(m);
        return GW'(a) + w_m + GW'(b);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_top[i] <= '0;
                r_mid[i] <= '0;
                r_bot[i] <= '0;
            end
        end else if (i_shift) begin
            r_top[0] <= r_top[1];
            r_top[1] <= r_top[2];
            r_top[2] <= i_top;
            r_mid[0] <= r_mid[1];
            r_mid[1] <= r_mid[2];
            r_mid[2] <= i_mid;
            r_bot[0] <= r_bot[1];
            r_bot[1] <= r_bot[2];
            r_bot[2] <= i_bot;
        end
    end

    assign w_gx_pos = tap3(r_top[2], r_mid[2], r_bot[2], i_sobel);
    assign w_gx_neg = tap3(r_top[0], r_mid[0], r_bot[0], i_sobel);
    assign w_gy_pos = tap3(r_bot[0], r_bot[1], r_bot[2], i_sobel);
    assign w_gy_neg = tap3(r_top[0], r_top[1], r_top[2], i_sobel);

    assign w_abs_gx = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
    assign w_abs_gy = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx  <= '0;
            r_gy  <= '0;
            r_mag <= '0;
        end else begin
            r_gx  <= $signed(w_gx_pos - w_gx_neg);
            r_gy  <= $signed(w_gy_pos - w_gy_neg);
            r_mag <= w_abs_gx + w_abs_gy;
        end
    end

    assign w_sat = (|r_mag[GW-1:DW]) ? c_pix_max : r_mag[DW-1:0];

`ifdef EDGE_THRESH_EN
    assign w_res = (w_sat >= i_thr) ? c_pix_max : '0;
`else
    logic w_thr_unused;
    assign w_thr_unused = ^i_thr;
    assign w_res = w_sat;
`endif

    // Output holds its last result between valid cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (i_load) begin
            r_dout <= i_border ? '0 : w_res;
        end
    end

    assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/edge_grad_3x3.sv
// +------------------------------------------------------------------------+
// | edge_grad_3x3                                                          |
// | Multi-channel 3x3 Prewitt/Sobel gradient magnitude with column-based   |
// | border blanking. Define EDGE_THRESH_EN for binarised output.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module edge_grad_3x3
    import edge_pkg::*;
#(
    parameter int PIC_WIDTH = 250,
    parameter int DW        = 8,
    parameter int CH        = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic           kernel_sel,
    input  logic [DW-1:0]  thr,
    input  logic [CH*DW-1:0] din1,
    input  logic [CH*DW-1:0] din2,
    input  logic [CH*DW-1:0] din3,
    output logic [CH*DW-1:0] dout,
    output logic           valid_out
);

    localparam int CW = col_w(PIC_WIDTH);
    localparam logic [CW-1:0] c_col_last = CW'(PIC_WIDTH - 1);

    logic [CW-1:0]         r_col;
    logic [EDGE_LAT-1:0]   r_valid;
    logic [EDGE_LAT-2:0]   r_border;
    kernel_e               r_ks;
    logic                  w_border;

    assign w_border = (int'(r_col) < 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
        end else if (!valid_in) begin
            r_col <= '0;
        end else if (r_col == c_col_last) begin
            r_col <= '0;
        end else begin
            r_col <= r_col + 1'b1;
        end
    end

    // Stage 0 is the window; kernel choice rides with the window contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_border <= '0;
            r_ks     <= KERNEL_PREWITT;
        end else begin
            r_valid  <= {r_valid[EDGE_LAT-2:0], valid_in};
            r_border <= {r_border[EDGE_LAT-3:0], w_border};
            if (valid_in) begin
                r_ks <= kernel_e'(kernel_sel);
            end
        end
    end

    assign valid_out = r_valid[EDGE_LAT-1];

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            edge_grad_ch #(
                .DW (DW)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_shift  (valid_in),
                .i_sobel  (r_ks == KERNEL_SOBEL),
                .i_load   (r_valid[EDGE_LAT-2]),
                .i_border (r_border[EDGE_LAT-2]),
                .i_thr    (thr),
                .i_top    (din1[c*DW +: DW]),
                .i_mid    (din2[c*DW +: DW]),
                .i_bot    (din3[c*DW +: DW]),
                .o_dout   (dout[c*DW +: DW])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_edge_grad_3x3.sv
// +------------------------------------------------------------------------+
// | tb_edge_grad_3x3                                                       |
// | Self-checking bench: directed vector table, reset corner case and      |
// | randomized traffic against a reference model (honours EDGE_THRESH_EN). |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_edge_grad_3x3;

    localparam int PW = 6;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam logic [DW-1:0] THR = 8'd100;
`ifdef EDGE_THRESH_EN
    localparam bit THR_MODE = 1'b1;
`else
    localparam bit THR_MODE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_in;
    logic             kernel_sel;
    logic [DW-1:0]    thr;
    logic [CH*DW-1:0] din1, din2, din3;
    logic [CH*DW-1:0] dout;
    logic             valid_out;

    edge_grad_3x3 #(
        .PIC_WIDTH (PW),
        .DW        (DW),
        .CH        (CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .kernel_sel (kernel_sel),
        .thr        (thr),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .dout       (dout),
        .valid_out  (valid_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit               v;
        logic [CH*DW-1:0] d;
    } slot_t;

    int               m_win [CH][3][3];
    int               m_pos;
    slot_t            m_pipe [4];
    bit               m_vout;
    logic [CH*DW-1:0] m_dout;
    logic [CH*DW-1:0] got_q [$];

    typedef struct {
        bit            gap;
        bit            ks;
        logic [DW-1:0] top, mid, bot;
        logic [DW-1:0] exp_plain, exp_thr;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [CH*DW-1:0] got,
                         input logic [CH*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    m_win[c][r][k] = 0;
        m_pos = 0;
        for (int i = 0; i < 4; i++) begin
            m_pipe[i].v = 1'b0;
            m_pipe[i].d = '0;
        end
        m_vout = 1'b0;
        m_dout = '0;
    endtask

    // Reference: direct evaluation of the gradient formulas on the last
    // three accepted columns, then a plain 4-deep delay line.
    task automatic model_step(input bit r, input bit v, input bit ks,
                              input logic [CH*DW-1:0] a, input logic [CH*DW-1:0] b,
                              input logic [CH*DW-1:0] c3);
        slot_t s;
        int    w, gx, gy, mag, sat, res;
        bit    border;
        if (r) begin
            model_reset();
            return;
        end
        s.v = v;
        s.d = '0;
        if (v) begin
            border = (m_pos < 2);
            w = ks ? 2 : 1;
            for (int c = 0; c < CH; c++) begin
                for (int rr = 0; rr < 3; rr++) begin
                    m_win[c][rr][0] = m_win[c][rr][1];
                    m_win[c][rr][1] = m_win[c][rr][2];
                end
                m_win[c][0][2] = int'(a[c*DW +: DW]);
                m_win[c][1][2] = int'(b[c*DW +: DW]);
                m_win[c][2][2] = int'(c3[c*DW +: DW]);
                gx = (m_win[c][0][2] + w*m_win[c][1][2] + m_win[c][2][2])
                   - (m_win[c][0][0] + w*m_win[c][1][0] + m_win[c][2][0]);
                gy = (m_win[c][2][0] + w*m_win[c][2][1] + m_win[c][2][2])
                   - (m_win[c][0][0] + w*m_win[c][0][1] + m_win[c][0][2]);
                mag = iabs(gx) + iabs(gy);
                sat = (mag > 255) ? 255 : mag;
                if (THR_MODE) res = (sat >= int'(THR)) ? 255 : 0;
                else          res = sat;
                if (border) res = 0;
                s.d[c*DW +: DW] = DW'(res);
            end
            m_pos = (m_pos == PW-1) ? 0 : m_pos + 1;
        end else begin
            m_pos = 0;
        end
        for (int i = 3; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = s;
        m_vout = m_pipe[3].v;
        if (m_vout) m_dout = m_pipe[3].d;
    endtask

    task automatic tick(input bit r, input bit v, input bit ks,
                        input logic [CH*DW-1:0] a, input logic [CH*DW-1:0] b,
                        input logic [CH*DW-1:0] c3);
        rst        = r;
        valid_in   = v;
        kernel_sel = ks;
        din1       = a;
        din2       = b;
        din3       = c3;
        @(posedge clk);
        #1;
        model_step(r, v, ks, a, b, c3);
        check("valid_out", {{(CH*DW-1){1'b0}}, valid_out}, {{(CH*DW-1){1'b0}}, m_vout});
        check("dout_model", dout, m_dout);
        if (valid_out) got_q.push_back(dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [CH*DW-1:0] rep(input logic [DW-1:0] p);
        return {CH{p}};
    endfunction

    task automatic add(input bit gap, input bit ks, input logic [DW-1:0] t,
                       input logic [DW-1:0] m, input logic [DW-1:0] b,
                       input logic [DW-1:0] ep, input logic [DW-1:0] et);
        vec_t e;
        e.gap = gap; e.ks = ks; e.top = t; e.mid = m; e.bot = b;
        e.exp_plain = ep; e.exp_thr = et;
        tbl.push_back(e);
    endtask

    task automatic add_vstep(input bit ks4, input bit ks5, input bit gap,
                             input logic [DW-1:0] e4p, input logic [DW-1:0] e5p,
                             input logic [DW-1:0] e4t, input logic [DW-1:0] e5t);
        add(gap,  ks4, 10, 10, 10, 0, 0);
        add(1'b0, ks4, 10, 10, 10, 0, 0);
        add(1'b0, ks4, 10, 10, 10, 0, 0);
        add(1'b0, ks4, 40, 40, 40, e4p, e4t);
        add(1'b0, ks5, 40, 40, 40, e5p, e5t);
        add(1'b0, ks5, 40, 40, 40, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] exp_px;
        thr = THR;
        model_reset();
        tick(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("reset_dout", dout, '0);
        check("reset_valid", {{(CH*DW-1){1'b0}}, valid_out}, '0);

        // Flat field, 10 columns (wraps at PW=6 with no visible effect)
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 100, 100, 100, 0, 0);
        // Vertical step, Prewitt, after a gap
        add_vstep(1'b0, 1'b0, 1'b1, 90, 90, 0, 0);
        // Same line again with no gap: relies on column wrap for the border
        add_vstep(1'b0, 1'b0, 1'b0, 90, 90, 0, 0);
        // Vertical step, Sobel
        add_vstep(1'b1, 1'b1, 1'b1, 120, 120, 8'hFF, 8'hFF);
        // Kernel switched mid-line
        add_vstep(1'b0, 1'b1, 1'b1, 90, 120, 0, 8'hFF);
        // Horizontal edge, Sobel, saturating
        add(1'b1, 1'b1, 255, 128, 0, 0, 0);
        add(1'b0, 1'b1, 255, 128, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 255, 128, 0, 255, 8'hFF);

        got_q.delete();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].gap) idle(2);
            tick(1'b0, 1'b1, tbl[i].ks, rep(tbl[i].top), rep(tbl[i].mid), rep(tbl[i].bot));
        end
        idle(6);
        check("table_count", got_q.size(), tbl.size());
        for (int i = 0; i < tbl.size() && i < got_q.size(); i++) begin
            exp_px = THR_MODE ? tbl[i].exp_thr : tbl[i].exp_plain;
            check($sformatf("table[%0d]", i), got_q[i], rep(exp_px));
        end

        // Reset with three results in flight
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, rep(200), rep(50), rep(0));
        got_q.delete();
        tick(1'b1, 1'b1, 1'b1, rep(200), rep(50), rep(0));
        check("rst_flush_dout", dout, '0);
        check("rst_flush_valid", {{(CH*DW-1){1'b0}}, valid_out}, '0);
        idle(5);
        check("no_stale_count", got_q.size(), 0);
        tick(1'b0, 1'b1, 1'b0, rep(0), rep(0), rep(0));
        tick(1'b0, 1'b1, 1'b0, rep(0), rep(0), rep(0));
        tick(1'b0, 1'b1, 1'b0, rep(200), rep(200), rep(200));
        idle(5);
        check("post_rst_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("post_rst_0", got_q[0], '0);
            check("post_rst_1", got_q[1], '0);
            check("post_rst_2", got_q[2], rep(8'hFF));
        end

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 500; i++) begin
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), CH*DW'($urandom), CH*DW'($urandom),
                 CH*DW'($urandom));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
